// File: rtl/keypad_pkg.sv
// Key codes and FSM state encoding shared by the keypad entry controller and its bench.
package keypad_pkg;

    localparam logic [3:0] KEY_SEL = 4'hA;
    localparam logic [3:0] KEY_BS  = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_ENT = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EDIT = 2'd1,
        ST_CONV = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Scanner key input and configuration write bus; the controller is the master of cfg writes.
interface keypad_entry_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 17
);
    logic [3:0]        keycode_i;
    logic              keytrig_i;
    logic              cfg_wr_o;
    logic [ADDR_W-1:0] cfg_addr_o;
    logic [DATA_W-1:0] cfg_data_o;

    modport master (
        input  keycode_i, keytrig_i,
        output cfg_wr_o, cfg_addr_o, cfg_data_o
    );

    modport slave (
        output keycode_i, keytrig_i,
        input  cfg_wr_o, cfg_addr_o, cfg_data_o
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one digit per clock from the most significant digit.
// The MSD is folded in on the start edge (acc starts at 0, so 0*10+d = d); done pulses after DIGITS edges.
module bcd2bin_seq #(
    parameter int DIGITS = 5,
    parameter int DATA_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  done,
    output logic [DATA_W-1:0]     bin
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic             run;
    logic [IDX_W-1:0] idx;
    logic [3:0]       digit;

    assign digit = bcd[{idx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            run  <= 1'b0;
            idx  <= '0;
            done <= 1'b0;
            bin  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin  <= DATA_W'(bcd[4*DIGITS-1 -: 4]);
                idx  <= IDX_W'(DIGITS - 2);
                run  <= (DIGITS > 1);
                done <= (DIGITS == 1);
            end else if (run) begin
                bin <= (bin << 3) + (bin << 1) + DATA_W'(digit);
                if (idx == '0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: builds a decimal entry from scanner keys and commits it as a config write.
//   state   | meaning
//   ST_IDLE | no digits entered, accepting keys
//   ST_EDIT | one or more digits entered, accepting keys
//   ST_CONV | BCD-to-binary conversion running, keys dropped
//   ST_CHK  | range check, issue write or flag error, then clear entry
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int   DIGITS      = 5,
    parameter int   DATA_W      = 17,
    parameter int   ADDR_W      = 2,
    parameter int   MAX_VALUE   = 99999,
    parameter logic TRIG_ACTIVE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    keypad_entry_ctrl_if.master     bus,
    output logic [4*DIGITS-1:0]     disp_bcd_o,
    output logic [2:0]              digit_cnt_o,
    output logic [ADDR_W-1:0]       target_o,
    output logic                    busy_o,
    output logic                    err_o
);
    localparam int                BW    = 4 * DIGITS;
    localparam logic [2:0]        DIG_N = 3'(DIGITS);
    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VALUE);

    state_t            state;
    logic              trig_q;
    logic              key_evt;
    logic              accept;
    logic              is_digit;
    logic              key_ignored;
    logic              conv_start;
    logic              conv_done;
    logic [DATA_W-1:0] conv_bin;

    assign key_evt     = (bus.keytrig_i == TRIG_ACTIVE) && (trig_q != TRIG_ACTIVE);
    assign accept      = key_evt && ((state == ST_IDLE) || (state == ST_EDIT));
    assign is_digit    = (bus.keycode_i <= 4'd9);
    assign key_ignored = (bus.keycode_i >= 4'hE) ||
                         ((bus.keycode_i == 4'd0) && (digit_cnt_o == 3'd0));
    assign conv_start  = accept && (bus.keycode_i == KEY_ENT);

    bcd2bin_seq #(
        .DIGITS (DIGITS),
        .DATA_W (DATA_W)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bcd   (disp_bcd_o),
        .done  (conv_done),
        .bin   (conv_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            trig_q         <= TRIG_ACTIVE;
            disp_bcd_o     <= '0;
            digit_cnt_o    <= '0;
            target_o       <= '0;
            busy_o         <= 1'b0;
            err_o          <= 1'b0;
            bus.cfg_wr_o   <= 1'b0;
            bus.cfg_addr_o <= '0;
            bus.cfg_data_o <= '0;
        end else begin
            trig_q       <= bus.keytrig_i;
            bus.cfg_wr_o <= 1'b0;
            case (state)
                ST_IDLE, ST_EDIT: begin
                    if (accept && !key_ignored) begin
                        err_o <= 1'b0;
                        if (is_digit) begin
                            if (digit_cnt_o == DIG_N) begin
                                err_o <= 1'b1;
                            end else begin
                                disp_bcd_o  <= (disp_bcd_o << 4) | BW'(bus.keycode_i);
                                digit_cnt_o <= digit_cnt_o + 3'd1;
                                state       <= ST_EDIT;
                            end
                        end else begin
                            case (bus.keycode_i)
                                KEY_SEL: begin
                                    target_o    <= target_o + ADDR_W'(1);
                                    disp_bcd_o  <= '0;
                                    digit_cnt_o <= '0;
                                    state       <= ST_IDLE;
                                end
                                KEY_BS: begin
                                    if (digit_cnt_o != 3'd0) begin
                                        disp_bcd_o  <= disp_bcd_o >> 4;
                                        digit_cnt_o <= digit_cnt_o - 3'd1;
                                        if (digit_cnt_o == 3'd1) state <= ST_IDLE;
                                    end
                                end
                                KEY_CLR: begin
                                    disp_bcd_o  <= '0;
                                    digit_cnt_o <= '0;
                                    state       <= ST_IDLE;
                                end
                                KEY_ENT: begin
                                    busy_o <= 1'b1;
                                    state  <= ST_CONV;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CONV: begin
                    if (conv_done) state <= ST_CHK;
                end
                ST_CHK: begin
                    if (conv_bin <= MAX_V) begin
                        bus.cfg_wr_o   <= 1'b1;
                        bus.cfg_addr_o <= target_o;
                        bus.cfg_data_o <= conv_bin;
                    end else begin
                        err_o <= 1'b1;
                    end
                    disp_bcd_o  <= '0;
                    digit_cnt_o <= '0;
                    busy_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: default instance plus a MAX_VALUE=50000 instance on one key stream.
module tb_keypad_entry_ctrl;
    import keypad_pkg::*;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] keycode = 4'h0;
    logic       keytrig = 1'b0;

    always #5 clk = ~clk;

    keypad_entry_ctrl_if #(.ADDR_W(2), .DATA_W(17)) bus0 ();
    keypad_entry_ctrl_if #(.ADDR_W(2), .DATA_W(17)) bus1 ();

    assign bus0.keycode_i = keycode;
    assign bus0.keytrig_i = keytrig;
    assign bus1.keycode_i = keycode;
    assign bus1.keytrig_i = keytrig;

    logic [19:0] disp0, disp1;
    logic [2:0]  cnt0, cnt1;
    logic [1:0]  tgt0, tgt1;
    logic        busy0, busy1, err0, err1;

    keypad_entry_ctrl dut0 (
        .clk (clk), .rst (rst), .bus (bus0),
        .disp_bcd_o (disp0), .digit_cnt_o (cnt0), .target_o (tgt0),
        .busy_o (busy0), .err_o (err0)
    );

    keypad_entry_ctrl #(.MAX_VALUE(50000)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1),
        .disp_bcd_o (disp1), .digit_cnt_o (cnt1), .target_o (tgt1),
        .busy_o (busy1), .err_o (err1)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int ent_cyc = 0;
    int wr_cnt0 = 0;
    int wr_cnt1 = 0;
    int wr_cyc0 = 0;
    int w0 = 0;
    int w1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write strobes are sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus0.cfg_wr_o) begin
            wr_cnt0 = wr_cnt0 + 1;
            wr_cyc0 = cyc;
        end
        if (bus1.cfg_wr_o) wr_cnt1 = wr_cnt1 + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        else n_pass = n_pass + 1;
    endtask

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        keycode = c;
        keytrig = 1'b1;
        @(negedge clk);
        ent_cyc = cyc;
        keytrig = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy0 || busy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy0 | busy1), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_disp",  32'(disp0), 32'd0);
        chk("rst_cnt",   32'(cnt0), 32'd0);
        chk("rst_tgt",   32'(tgt0), 32'd0);
        chk("rst_busy",  32'(busy0), 32'd0);
        chk("rst_err",   32'(err0), 32'd0);
        chk("rst_wr",    32'(bus0.cfg_wr_o), 32'd0);
        chk("rst_data",  32'(bus0.cfg_data_o), 32'd0);

        // 1,2,3,Enter -> write 123 to target 0
        press(4'd1); press(4'd2); press(4'd3);
        chk("t1_disp", 32'(disp0), 32'h00123);
        chk("t1_cnt",  32'(cnt0), 32'd3);
        w0 = wr_cnt0;
        press(KEY_ENT);
        chk("t1_busy", 32'(busy0), 32'd1);
        wait_idle();
        chk("t1_wr_once", 32'(wr_cnt0 - w0), 32'd1);
        chk("t1_latency", 32'(wr_cyc0 - ent_cyc), 32'd6);
        chk("t1_addr",    32'(bus0.cfg_addr_o), 32'd0);
        chk("t1_data",    32'(bus0.cfg_data_o), 32'd123);
        chk("t1_disp_clr", 32'(disp0), 32'd0);
        chk("t1_cnt_clr",  32'(cnt0), 32'd0);

        // Overflow digit then Enter on target 2 -> 99999
        press(KEY_SEL); press(KEY_SEL);
        chk("t2_tgt", 32'(tgt0), 32'd2);
        for (int i = 0; i < 5; i++) press(4'd9);
        press(4'd7);
        chk("t2_ovf_err",  32'(err0), 32'd1);
        chk("t2_ovf_disp", 32'(disp0), 32'h99999);
        chk("t2_ovf_cnt",  32'(cnt0), 32'd5);
        w0 = wr_cnt0;
        press(KEY_ENT);
        chk("t2_err_clr", 32'(err0), 32'd0);
        wait_idle();
        chk("t2_wr_once", 32'(wr_cnt0 - w0), 32'd1);
        chk("t2_addr",    32'(bus0.cfg_addr_o), 32'd2);
        chk("t2_data",    32'(bus0.cfg_data_o), 32'd99999);
        for (int i = 0; i < 5; i++) press(KEY_SEL);
        chk("t2_tgt_wrap", 32'(tgt0), 32'd3);

        // MAX_VALUE=50000 instance: 60000 rejected, 50000 accepted
        press(KEY_CLR);
        chk("t3_clr_err", 32'(err1), 32'd0);
        w0 = wr_cnt0;
        w1 = wr_cnt1;
        press(4'd6);
        for (int i = 0; i < 4; i++) press(4'd0);
        press(KEY_ENT);
        wait_idle();
        chk("t3_rej_nowr", 32'(wr_cnt1 - w1), 32'd0);
        chk("t3_rej_err",  32'(err1), 32'd1);
        chk("t3_rej_cnt",  32'(cnt1), 32'd0);
        chk("t3_dflt_data", 32'(bus0.cfg_data_o), 32'd60000);
        chk("t3_dflt_wr",   32'(wr_cnt0 - w0), 32'd1);
        press(KEY_CLR);
        chk("t3_c_err", 32'(err1), 32'd0);
        w1 = wr_cnt1;
        press(4'd5);
        for (int i = 0; i < 4; i++) press(4'd0);
        press(KEY_ENT);
        wait_idle();
        chk("t3_max_wr",   32'(wr_cnt1 - w1), 32'd1);
        chk("t3_max_data", 32'(bus1.cfg_data_o), 32'd50000);
        chk("t3_max_err",  32'(err1), 32'd0);

        // Leading zeros, backspace, clear, empty enter
        press(4'd0); press(4'd0);
        chk("t4_lead0_cnt", 32'(cnt0), 32'd0);
        press(4'd4); press(4'd5);
        chk("t4_cnt2",  32'(cnt0), 32'd2);
        chk("t4_disp45", 32'(disp0), 32'h00045);
        press(KEY_BS);
        chk("t4_bs_disp", 32'(disp0), 32'h00004);
        chk("t4_bs_cnt",  32'(cnt0), 32'd1);
        press(4'd7);
        chk("t4_disp47", 32'(disp0), 32'h00047);
        press(KEY_ENT);
        wait_idle();
        chk("t4_data47", 32'(bus0.cfg_data_o), 32'd47);
        chk("t4_addr3",  32'(bus0.cfg_addr_o), 32'd3);
        press(4'd8); press(KEY_CLR);
        chk("t4_clr_disp", 32'(disp0), 32'd0);
        chk("t4_clr_cnt",  32'(cnt0), 32'd0);
        w0 = wr_cnt0;
        press(KEY_ENT);
        wait_idle();
        chk("t4_empty_wr",   32'(wr_cnt0 - w0), 32'd1);
        chk("t4_empty_data", 32'(bus0.cfg_data_o), 32'd0);

        // Keys during CONV/CHK are dropped
        press(4'd2);
        w0 = wr_cnt0;
        press(KEY_ENT);
        press(4'd7);
        press(4'd8);
        wait_idle();
        chk("t5_busy_wr",   32'(wr_cnt0 - w0), 32'd1);
        chk("t5_busy_data", 32'(bus0.cfg_data_o), 32'd2);
        chk("t5_busy_cnt",  32'(cnt0), 32'd0);
        chk("t5_busy_disp", 32'(disp0), 32'd0);

        // Reset in the third CONV cycle aborts with no strobe
        press(4'd9);
        w0 = wr_cnt0;
        @(negedge clk); keycode = KEY_ENT; keytrig = 1'b1;
        @(negedge clk); keytrig = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_conv", 32'(busy0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_nowr",  32'(wr_cnt0 - w0), 32'd0);
        chk("t6_disp",  32'(disp0), 32'd0);
        chk("t6_cnt",   32'(cnt0), 32'd0);
        chk("t6_tgt",   32'(tgt0), 32'd0);
        chk("t6_busy",  32'(busy0), 32'd0);
        chk("t6_err",   32'(err0), 32'd0);
        chk("t6_addr",  32'(bus0.cfg_addr_o), 32'd0);
        chk("t6_data",  32'(bus0.cfg_data_o), 32'd0);

        // Held key gives exactly one digit
        @(negedge clk); keycode = 4'd5; keytrig = 1'b1;
        repeat (1000) @(negedge clk);
        keytrig = 1'b0;
        @(negedge clk);
        chk("t7_hold_cnt",  32'(cnt0), 32'd1);
        chk("t7_hold_disp", 32'(disp0), 32'h00005);

        // Key held across reset release gives no event
        @(negedge clk); keycode = 4'd3; keytrig = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        keytrig = 1'b0;
        @(negedge clk);
        chk("t8_rstheld_cnt", 32'(cnt0), 32'd0);
        press(4'd6);
        chk("t8_after_disp", 32'(disp0), 32'h00006);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
